// File: rtl/burst_mem_responder_pkg.sv
// Shared types and constants for the burst memory responder.
package burst_mem_responder_pkg;

   // Beats per 256-bit line at 64 bits per beat.
   localparam int burst_beats = 4;

   // Responder FSM: accept -> fixed latency -> beat train -> one turnaround cycle.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/burst_mem_array.sv
// Line storage for the burst memory responder: one port, synchronous write,
// asynchronous read, indexed by {line, beat}.
module burst_mem_array #(
   parameter int DATA_WIDTH = 64,
   parameter int IDX_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [IDX_WIDTH-1:0]  addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**IDX_WIDTH];

   // Contents are deliberately left out of reset so data survives an abort.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: line-granular physical memory model for the pmem burst
// interface. A request is accepted in IDLE, LATENCY idle cycles follow, then
// BURST_LEN beats with pmem_resp high, then one DONE cycle that ignores requests.
//
// Handshake: the initiator raises exactly one of pmem_read/pmem_write with a
// stable pmem_address and holds it until the cycle of the last pmem_resp; each
// cycle with pmem_resp high transfers one beat (read data on pmem_rdata, write
// data taken from pmem_wdata at the closing edge). The initiator may keep the
// request high through DONE; a request still high in IDLE starts a new line.
//
// Optional feature: define BURST_MEM_PROTOCOL_CHECK_EN to build the sticky
// protocol checker driving proto_err; otherwise proto_err is tied low.
module burst_mem_responder
   import burst_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 64,
   parameter int BURST_LEN   = burst_beats,
   parameter int DEPTH_LINES = 256,
   parameter int LATENCY     = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pmem_read,
   input  logic                  pmem_write,
   input  logic [ADDR_WIDTH-1:0] pmem_address,
   input  logic [DATA_WIDTH-1:0] pmem_wdata,
   output logic [DATA_WIDTH-1:0] pmem_rdata,
   output logic                  pmem_resp,
   output logic                  proto_err,
   output state_t                dbg_state_o
);

   localparam int LINE_BITS = $clog2(DEPTH_LINES);
   localparam int BEAT_BITS = $clog2(BURST_LEN);
   localparam int OFS_BITS  = $clog2(BURST_LEN * DATA_WIDTH / 8);
   localparam int WCNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t                  state_q, state_d;
   logic [WCNT_BITS-1:0]    wait_cnt_q, wait_cnt_d;
   logic [BEAT_BITS-1:0]    beat_cnt_q, beat_cnt_d;
   logic [LINE_BITS-1:0]    line_q, line_d;
   logic                    op_write_q, op_write_d;
   logic                    resp_q, resp_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

   logic                              req_one;
   logic                              mem_we;
   logic [LINE_BITS+BEAT_BITS-1:0]    mem_addr;
   logic [DATA_WIDTH-1:0]             mem_rdata;
   logic                              addr_unused;

   // Offset bits within a line and the aliasing bits above the index never matter to the datapath.
   assign addr_unused = ^{pmem_address[OFS_BITS-1:0], pmem_address[ADDR_WIDTH-1:OFS_BITS+LINE_BITS]};

   assign req_one = pmem_read ^ pmem_write;

   // Next-state, counters and latched request fields.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      beat_cnt_d = beat_cnt_q;
      line_d     = line_q;
      op_write_d = op_write_q;
      case (state_q)
         S_IDLE: begin
            if (req_one) begin
               op_write_d = pmem_write;
               line_d     = pmem_address[OFS_BITS +: LINE_BITS];
               wait_cnt_d = WCNT_BITS'(LATENCY - 1);
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_cnt_q == '0) begin
               beat_cnt_d = '0;
               state_d    = S_BURST;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         S_BURST: begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (beat_cnt_q == BEAT_BITS'(BURST_LEN - 1)) begin
               beat_cnt_d = '0;
               state_d    = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Writes land on the edge closing the current beat; reads prefetch the beat the
   // next cycle will present, so the array address follows the operation type.
   always_comb begin
      mem_we   = reset_n && (state_q == S_BURST) && op_write_q;
      mem_addr = op_write_q ? {line_q, beat_cnt_q} : {line_d, beat_cnt_d};
      resp_d   = (state_d == S_BURST);
      rdata_d  = (resp_d && !op_write_q) ? mem_rdata : '0;
   end

   // State and output registers; reset aborts any burst but leaves the array alone.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         beat_cnt_q <= '0;
         line_q     <= '0;
         op_write_q <= 1'b0;
         resp_q     <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         line_q     <= line_d;
         op_write_q <= op_write_d;
         resp_q     <= resp_d;
         rdata_q    <= rdata_d;
      end
   end

   burst_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_WIDTH  (LINE_BITS + BEAT_BITS)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (pmem_wdata),
      .rdata_o (mem_rdata)
   );

   assign pmem_resp   = resp_q;
   assign pmem_rdata  = rdata_q;
   assign dbg_state_o = state_q;

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
   logic [ADDR_WIDTH-OFS_BITS-1:0] tag_q, tag_d;
   logic                           proto_err_q, proto_err_d;
   logic                           viol;

   // Flag conflicting requests anywhere, and tag/op changes or drops while a line is in flight.
   always_comb begin
      tag_d = tag_q;
      viol  = pmem_read && pmem_write;
      if (state_q == S_IDLE && req_one) begin
         tag_d = pmem_address[ADDR_WIDTH-1:OFS_BITS];
      end
      if (state_q == S_WAIT || state_q == S_BURST) begin
         if (pmem_address[ADDR_WIDTH-1:OFS_BITS] != tag_q) viol = 1'b1;
         if (op_write_q ? !pmem_write : !pmem_read)        viol = 1'b1;
      end
      proto_err_d = proto_err_q | viol;
   end

   // Sticky error flag and the line tag captured at acceptance.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tag_q       <= '0;
         proto_err_q <= 1'b0;
      end else begin
         tag_q       <= tag_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign proto_err = proto_err_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule
